// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: sequences init, auto-refresh, write and read sequencers
// onto a single SDRAM command bus, with a free-running refresh-interval timer.
module sdram_arbit #(
  parameter logic [9:0] REF_CYC = 10'd749,
  parameter logic [3:0] NOP     = 4'b0111
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        init_end,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        ref_end,
  input  logic        flag_wr_end,
  input  logic        flag_rd_end,
  input  logic [3:0]  init_cmd,
  input  logic [3:0]  ref_cmd,
  input  logic [3:0]  wr_cmd,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] init_addr,
  input  logic [11:0] ref_addr,
  input  logic [11:0] wr_addr,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  output logic [4:0]  state,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ref_req,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank
);

  typedef enum logic [4:0] {
    AREF  = 5'b00000,
    IDLE  = 5'b00001,
    INIT  = 5'b00010,
    WRITE = 5'b00100,
    READ  = 5'b01000
  } state_t;

  state_t      state_r;
  logic        ref_en_r;
  logic        wr_en_r;
  logic        rd_en_r;
  logic        ref_req_r;
  logic [9:0]  cnt_r;
  logic        ref_grant_s;
  logic        cnt_wrap_s;
  logic [3:0]  cmd_s;
  logic [11:0] addr_s;
  logic [1:0]  bank_s;

  // Refresh is granted on the same edge that clears its request flag.
  assign ref_grant_s = (state_r == IDLE) && ref_req_r;
  assign cnt_wrap_s  = init_end && (cnt_r == REF_CYC);

  // Arbiter FSM with registered one-cycle grant pulses; bursts are never preempted.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_r  <= INIT;
      ref_en_r <= 1'b0;
      wr_en_r  <= 1'b0;
      rd_en_r  <= 1'b0;
    end else begin
      ref_en_r <= 1'b0;
      wr_en_r  <= 1'b0;
      rd_en_r  <= 1'b0;
      case (state_r)
        INIT: begin
          if (init_end) state_r <= IDLE;
        end
        IDLE: begin
          if (ref_req_r) begin
            state_r  <= AREF;
            ref_en_r <= 1'b1;
          end else if (wr_req) begin
            state_r <= WRITE;
            wr_en_r <= 1'b1;
          end else if (rd_req) begin
            state_r <= READ;
            rd_en_r <= 1'b1;
          end
        end
        AREF: begin
          if (ref_end) state_r <= IDLE;
        end
        WRITE: begin
          if (flag_wr_end) state_r <= IDLE;
        end
        READ: begin
          if (flag_rd_end) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Refresh interval timer, idle until initialization has completed.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cnt_r <= 10'd0;
    end else if (!init_end) begin
      cnt_r <= 10'd0;
    end else if (cnt_wrap_s) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_r + 10'd1;
    end
  end

  // Refresh-due flag: a wrap sets it (winning over a same-cycle grant), a grant clears it.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      ref_req_r <= 1'b0;
    end else if (cnt_wrap_s) begin
      ref_req_r <= 1'b1;
    end else if (ref_grant_s) begin
      ref_req_r <= 1'b0;
    end else begin
      ref_req_r <= ref_req_r;
    end
  end

  // Command bus mux follows the current owner; unknown states drive NOP.
  always_comb begin
    cmd_s  = NOP;
    addr_s = 12'h000;
    bank_s = 2'b00;
    case (state_r)
      INIT: begin
        cmd_s  = init_cmd;
        addr_s = init_addr;
      end
      AREF: begin
        cmd_s  = ref_cmd;
        addr_s = ref_addr;
      end
      WRITE: begin
        cmd_s  = wr_cmd;
        addr_s = wr_addr;
        bank_s = wr_bank;
      end
      READ: begin
        cmd_s  = rd_cmd;
        addr_s = rd_addr;
        bank_s = rd_bank;
      end
      default: begin
        cmd_s  = NOP;
        addr_s = 12'h000;
        bank_s = 2'b00;
      end
    endcase
  end

  assign state      = state_r;
  assign ref_en     = ref_en_r;
  assign wr_en      = wr_en_r;
  assign rd_en      = rd_en_r;
  assign ref_req    = ref_req_r;
  assign sdram_cmd  = cmd_s;
  assign sdram_addr = addr_s;
  assign sdram_bank = bank_s;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: reset, init, refresh timing, priority,
// non-preemption, refresh coalescing, command muxing and reset mid-refresh.
module tb_sdram_arbit;

  localparam logic [4:0] S_AREF  = 5'b00000;
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_INIT  = 5'b00010;
  localparam logic [4:0] S_WRITE = 5'b00100;
  localparam logic [4:0] S_READ  = 5'b01000;

  logic        sclk;
  logic        s_rst;
  logic        init_end;
  logic        wr_req, rd_req;
  logic        ref_end, flag_wr_end, flag_rd_end;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, ref_addr, wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;
  logic [4:0]  state;
  logic        ref_en, wr_en, rd_en, ref_req;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  int total = 0;
  int bad   = 0;
  int ecount;

  sdram_arbit dut (
    .sclk(sclk), .s_rst(s_rst), .init_end(init_end),
    .wr_req(wr_req), .rd_req(rd_req),
    .ref_end(ref_end), .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
    .init_cmd(init_cmd), .ref_cmd(ref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .init_addr(init_addr), .ref_addr(ref_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .state(state), .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_req(ref_req),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge index counted from the first edge that sees init_end=1 (edge 0).
  task automatic tick();
    @(posedge sclk);
    #1;
    ecount++;
  endtask

  task automatic go_to(input int e);
    while (ecount < e) tick();
  endtask

  initial begin
    s_rst = 1'b1; init_end = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    init_cmd = 4'b0001; init_addr = 12'h400;
    ref_cmd  = 4'b0010; ref_addr  = 12'h555;
    wr_cmd   = 4'b0100; wr_addr   = 12'h123; wr_bank = 2'b10;
    rd_cmd   = 4'b0101; rd_addr   = 12'h01C; rd_bank = 2'b01;
    ecount = -100;

    repeat (2) tick();
    chk("rst_state", state, S_INIT);
    chk("rst_grants", {ref_en, wr_en, rd_en}, 3'b000);
    chk("rst_ref_req", ref_req, 1'b0);
    chk("rst_cmd", sdram_cmd, 4'b0001);
    chk("rst_addr", sdram_addr, 12'h400);
    chk("rst_bank", sdram_bank, 2'b00);

    s_rst = 1'b0;
    repeat (5) tick();
    chk("init_hold", state, S_INIT);

    // Initialization done; refresh becomes due 750 cycles later.
    init_end = 1'b1;
    ecount = -1;
    go_to(0);
    chk("init_to_idle", state, S_IDLE);
    chk("ref_req_early", ref_req, 1'b0);
    go_to(748);
    chk("ref_req_748", ref_req, 1'b0);
    go_to(749);
    chk("ref_req_749", ref_req, 1'b1);
    chk("no_grant_yet", ref_en, 1'b0);

    go_to(750);
    chk("aref_state", state, S_AREF);
    chk("aref_en", ref_en, 1'b1);
    chk("aref_req_clr", ref_req, 1'b0);
    chk("aref_cmd", sdram_cmd, 4'b0010);
    chk("aref_addr", sdram_addr, 12'h555);
    ref_end = 1'b1;
    go_to(751);
    chk("aref_done", state, S_IDLE);
    chk("aref_en_pulse", ref_en, 1'b0);
    ref_end = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    chk("idle_cmd", sdram_cmd, 4'b0111);
    chk("idle_addr", sdram_addr, 12'h000);

    // Write beats read; read follows after one IDLE cycle.
    go_to(752);
    chk("wr_state", state, S_WRITE);
    chk("wr_grants", {ref_en, wr_en, rd_en}, 3'b010);
    chk("wr_cmd", sdram_cmd, 4'b0100);
    chk("wr_addr", sdram_addr, 12'h123);
    chk("wr_bank", sdram_bank, 2'b10);
    wr_req = 1'b0;
    go_to(753);
    chk("wr_en_pulse", wr_en, 1'b0);
    chk("wr_hold", state, S_WRITE);
    flag_wr_end = 1'b1;
    go_to(754);
    chk("wr_end_idle", state, S_IDLE);
    chk("rd_gap", rd_en, 1'b0);
    flag_wr_end = 1'b0;
    go_to(755);
    chk("rd_state", state, S_READ);
    chk("rd_en", rd_en, 1'b1);
    chk("rd_cmd", sdram_cmd, 4'b0101);
    chk("rd_addr", sdram_addr, 12'h01C);
    chk("rd_bank", sdram_bank, 2'b01);
    rd_req = 1'b0;
    go_to(756);
    chk("rd_en_pulse", rd_en, 1'b0);
    flag_rd_end = 1'b1;
    go_to(757);
    chk("rd_end_idle", state, S_IDLE);
    flag_rd_end = 1'b0;

    // Refresh becomes due mid-write with wr_req still held.
    go_to(1489);
    wr_req = 1'b1;
    go_to(1490);
    chk("wr2_state", state, S_WRITE);
    go_to(1499);
    chk("wr2_ref_due", ref_req, 1'b1);
    chk("wr2_no_preempt", state, S_WRITE);
    go_to(1500);
    flag_wr_end = 1'b1;
    go_to(1501);
    chk("wr2_idle", state, S_IDLE);
    flag_wr_end = 1'b0;
    go_to(1502);
    chk("ref_over_wr", state, S_AREF);
    chk("ref_over_wr_en", {ref_en, wr_en}, 2'b10);
    go_to(1503);
    ref_end = 1'b1;
    go_to(1504);
    chk("aref2_idle", state, S_IDLE);
    ref_end = 1'b0;
    go_to(1505);
    chk("wr_regrant", state, S_WRITE);
    chk("wr_regrant_en", wr_en, 1'b1);
    wr_req = 1'b0; flag_wr_end = 1'b1;
    go_to(1506);
    chk("wr3_idle", state, S_IDLE);
    flag_wr_end = 1'b0;

    // Two wraps during a long read collapse into one refresh.
    go_to(1509);
    rd_req = 1'b1;
    go_to(1510);
    chk("rd2_state", state, S_READ);
    rd_req = 1'b0;
    go_to(2249);
    chk("rd2_ref_due", ref_req, 1'b1);
    go_to(2999);
    chk("rd2_ref_still", ref_req, 1'b1);
    chk("rd2_hold", state, S_READ);
    flag_rd_end = 1'b1;
    go_to(3000);
    chk("rd2_idle", state, S_IDLE);
    flag_rd_end = 1'b0;
    go_to(3001);
    chk("aref3_state", state, S_AREF);
    chk("aref3_req_clr", ref_req, 1'b0);
    ref_end = 1'b1;
    go_to(3002);
    ref_end = 1'b0;
    go_to(3010);
    chk("single_aref", state, S_IDLE);
    chk("single_aref_req", ref_req, 1'b0);

    // Reset during a refresh while another refresh is already due.
    go_to(3750);
    chk("aref4_state", state, S_AREF);
    go_to(4499);
    chk("aref4_req", ref_req, 1'b1);
    chk("aref4_hold", state, S_AREF);
    s_rst = 1'b1;
    go_to(4500);
    chk("rst2_state", state, S_INIT);
    chk("rst2_ref_req", ref_req, 1'b0);
    chk("rst2_grants", {ref_en, wr_en, rd_en}, 3'b000);
    chk("rst2_cmd", sdram_cmd, 4'b0001);
    s_rst = 1'b0;
    go_to(4501);
    chk("rst2_idle", state, S_IDLE);
    go_to(5249);
    chk("rst2_cnt_749", ref_req, 1'b0);
    go_to(5250);
    chk("rst2_cnt_750", ref_req, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
